// File: rtl/ropuf_response_gen.sv
// Ring-oscillator PUF response generator.
// For each of N_BITS RO pairs, counts rising edges of ro_a and ro_b over
// one full gate window, then records (cnt_a > cnt_b) as response bit sel.
module ropuf_response_gen #(
  parameter int N_BITS = 8,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              gate,
  input  logic              ro_a,
  input  logic              ro_b,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [N_BITS-1:0] response
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_BITS - 1);

  typedef enum logic [2:0] {IDLE, ARM, COUNT, COMPARE, NEXT} state_t;

  state_t state, state_next;

  // _p0/_p1 form the 2-FF synchronizer, _p2 is the edge-detect delay stage
  logic gate_p0, gate_p1, gate_p2;
  logic ro_a_p0, ro_a_p1, ro_a_p2;
  logic ro_b_p0, ro_b_p1, ro_b_p2;

  logic gate_rise, gate_fall, strobe_a, strobe_b;

  logic [CNT_W-1:0] cnt_a, cnt_b;

  // Saturating increment: holds at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             inc);
    if (inc && (c != {CNT_W{1'b1}}))
      return c + CNT_W'(1);
    else
      return c;
  endfunction

  // Synchronize asynchronous inputs and keep one delayed copy for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_p0 <= 1'b0; gate_p1 <= 1'b0; gate_p2 <= 1'b0;
      ro_a_p0 <= 1'b0; ro_a_p1 <= 1'b0; ro_a_p2 <= 1'b0;
      ro_b_p0 <= 1'b0; ro_b_p1 <= 1'b0; ro_b_p2 <= 1'b0;
    end else begin
      gate_p0 <= gate;    gate_p1 <= gate_p0;    gate_p2 <= gate_p1;
      ro_a_p0 <= ro_a;    ro_a_p1 <= ro_a_p0;    ro_a_p2 <= ro_a_p1;
      ro_b_p0 <= ro_b;    ro_b_p1 <= ro_b_p0;    ro_b_p2 <= ro_b_p1;
    end
  end

  // ---- edge detect stage (p1 vs p2) ----
  assign gate_rise = gate_p1 & ~gate_p2;
  assign gate_fall = ~gate_p1 & gate_p2;
  assign strobe_a  = ro_a_p1 & ~ro_a_p2;
  assign strobe_b  = ro_b_p1 & ~ro_b_p2;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; done fires while NEXT retires the last pair
  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE:    if (start) state_next = ARM;
      ARM:     if (gate_rise) state_next = COUNT;
      COUNT:   if (gate_fall) state_next = COMPARE;
      COMPARE: state_next = NEXT;
      NEXT: begin
        if (sel == LAST_SEL) begin
          state_next = IDLE;
          done       = 1'b1;
        end else begin
          state_next = ARM;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters, pair select, response capture and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel      <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      response <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel      <= '0;
            valid    <= 1'b0;
            response <= '0;
            busy     <= 1'b1;
          end
        end
        ARM: begin
          // waiting for a fresh rising edge discards any window already open
          cnt_a <= '0;
          cnt_b <= '0;
        end
        COUNT: begin
          // strobes coinciding with the gate falling edge still count
          cnt_a <= sat_inc(cnt_a, strobe_a);
          cnt_b <= sat_inc(cnt_b, strobe_b);
        end
        COMPARE: begin
          response[sel] <= (cnt_a > cnt_b);
        end
        NEXT: begin
          cnt_a <= '0;
          cnt_b <= '0;
          if (sel == LAST_SEL) begin
            busy  <= 1'b0;
            valid <= 1'b1;
          end else begin
            sel <= sel + SEL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
